pc_select_unit: RTL and testbench

Parametrised next-PC selection and program-counter register for the fetch stage. It chooses between the sequential increment and up to NUM_SRC prioritised redirect sources, such as branch, jump and exception. It holds the PC under stall and remembers a redirect that arrives while stalled. When a redirect takes effect it produces a one-cycle flush pulse for the IF/ID register. It sits between the instruction-memory address port and the branch/jump resolution logic, and replaces the two-input fetch multiplexer.

---
 rtl/pc_select_unit.sv | 130 +++++++++++++
 tb/tb_pc_select_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_select_unit.sv
// pc_select_unit: fetch-stage program counter with prioritised redirect
// selection, stall hold, and capture of a redirect that arrives while stalled.
// A redirect that takes effect raises flush for the cycle in which pc first
// shows the new address, so the IF/ID register can discard its wrong-path word.

module pc_select_unit #(
  parameter int unsigned         WIDTH    = 32,
  parameter int unsigned         NUM_SRC  = 3,
  parameter int unsigned         INC      = 4,
  parameter logic [WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [NUM_SRC-1:0]         redirect_valid,
  input  logic [NUM_SRC*WIDTH-1:0]   redirect_target,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_plus_inc,
  output logic                       flush,
  output logic                       redirect_pending
);

  // A single channel still needs one index bit to hold "channel 0".
  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // RUN: no redirect is waiting. HELD: a redirect was sampled under stall.
  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic               flush_q, flush_d;
  logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [WIDTH-1:0]   pend_target_q, pend_target_d;

  logic               new_redirect;
  logic [IDX_W-1:0]   win_idx;
  logic [WIDTH-1:0]   win_target;
  logic               take_new;

  // Sequential increment wraps modulo 2^WIDTH; this is the only output
  // that is combinational, and it depends on the registered pc alone.
  assign pc_plus_inc      = pc_q + WIDTH'(INC);
  assign pc               = pc_q;
  assign flush            = flush_q;
  assign redirect_pending = (state_q == HELD);

  // Priority encoder: scanning from the top down lets the lowest valid
  // index overwrite the result last, so channel 0 wins any tie.
  always_comb begin
    new_redirect = 1'b0;
    win_idx      = '0;
    win_target   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        new_redirect = 1'b1;
        win_idx      = IDX_W'(i);
        win_target   = redirect_target[i*WIDTH +: WIDTH];
      end
    end
  end

  // While HELD, a fresh request only matters if it is at least as urgent as
  // the one already captured; a lower-priority request is simply dropped.
  assign take_new = new_redirect && (win_idx <= pend_idx_q);

  // Next-state and next-pc selection for both states.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    pend_idx_d    = pend_idx_q;
    pend_target_d = pend_target_q;

    case (state_q)
      RUN: begin
        if (!stall) begin
          if (new_redirect) begin
            pc_d    = win_target;
            flush_d = 1'b1;
          end else begin
            pc_d    = pc_plus_inc;
          end
        end else if (new_redirect) begin
          pend_idx_d    = win_idx;
          pend_target_d = win_target;
          state_d       = HELD;
        end
      end

      HELD: begin
        if (stall) begin
          if (take_new) begin
            pend_idx_d    = win_idx;
            pend_target_d = win_target;
          end
        end else begin
          pc_d    = take_new ? win_target : pend_target_q;
          flush_d = 1'b1;
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Register update; reset wins over stall and every redirect on the same
  // edge and throws away any captured redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      pend_idx_q    <= '0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      pend_idx_q    <= pend_idx_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_pc_select_unit.sv
// tb_pc_select_unit: directed test of pc_select_unit in two configurations,
// a 32-bit three-channel unit and a 16-bit single-channel unit.

module tb_pc_select_unit;

  logic        clk;
  logic        reset;

  // Wide configuration signals.
  logic        a_stall;
  logic [2:0]  a_valid;
  logic [95:0] a_target;
  logic [31:0] a_pc;
  logic [31:0] a_pc_plus;
  logic        a_flush;
  logic        a_pending;

  // Narrow configuration signals.
  logic        b_reset;
  logic        b_stall;
  logic [0:0]  b_valid;
  logic [15:0] b_target;
  logic [15:0] b_pc;
  logic [15:0] b_pc_plus;
  logic        b_flush;
  logic        b_pending;

  int compared;
  int mismatched;

  pc_select_unit #(
    .WIDTH   (32),
    .NUM_SRC (3),
    .INC     (4),
    .RESET_PC(32'h0040_0000)
  ) dut_a (
    .clk             (clk),
    .reset           (reset),
    .stall           (a_stall),
    .redirect_valid  (a_valid),
    .redirect_target (a_target),
    .pc              (a_pc),
    .pc_plus_inc     (a_pc_plus),
    .flush           (a_flush),
    .redirect_pending(a_pending)
  );

  pc_select_unit #(
    .WIDTH   (16),
    .NUM_SRC (1),
    .INC     (2),
    .RESET_PC(16'h0010)
  ) dut_b (
    .clk             (clk),
    .reset           (b_reset),
    .stall           (b_stall),
    .redirect_valid  (b_valid),
    .redirect_target (b_target),
    .pc              (b_pc),
    .pc_plus_inc     (b_pc_plus),
    .flush           (b_flush),
    .redirect_pending(b_pending)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the wide unit's inputs, then let one rising edge pass; sampling
  // happens at the following falling edge, well clear of the active edge.
  task automatic applyStimulus(input logic stall_in, input logic [2:0] valid_in,
                               input logic [31:0] t0, input logic [31:0] t1,
                               input logic [31:0] t2);
    a_stall  = stall_in;
    a_valid  = valid_in;
    a_target = {t2, t1, t0};
    @(negedge clk);
  endtask

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    b_reset    = 1'b1;
    b_stall    = 1'b0;
    b_valid    = 1'b0;
    b_target   = '0;
    a_stall    = 1'b0;
    a_valid    = '0;
    a_target   = '0;
    @(negedge clk);

    // Reset held two cycles, then free run.
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("reset_pc",       a_pc,            32'h0040_0000);
    checkOutput("reset_flush",    {31'b0, a_flush},   32'h0);
    checkOutput("reset_pending",  {31'b0, a_pending}, 32'h0);
    checkOutput("reset_pc_plus",  a_pc_plus,       32'h0040_0004);
    reset = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("run_pc1",        a_pc,            32'h0040_0004);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("run_pc2",        a_pc,            32'h0040_0008);
    checkOutput("run_flush",      {31'b0, a_flush},   32'h0);

    // Priority: reach 0x100 via ch0, then ch1 and ch2 together back-to-back.
    applyStimulus(1'b0, 3'b001, 32'h100, 32'h0, 32'h0);
    checkOutput("redir_pc",       a_pc,            32'h100);
    checkOutput("redir_flush",    {31'b0, a_flush},   32'h1);
    applyStimulus(1'b0, 3'b110, 32'h0, 32'h200, 32'h300);
    checkOutput("prio_pc",        a_pc,            32'h200);
    checkOutput("b2b_flush",      {31'b0, a_flush},   32'h1);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("prio_next_pc",   a_pc,            32'h204);
    checkOutput("prio_flush_off", {31'b0, a_flush},   32'h0);

    // Stalled redirects: ch2 then ch0 captured, later ch2 dropped.
    applyStimulus(1'b0, 3'b001, 32'h40, 32'h0, 32'h0);
    checkOutput("to40_pc",        a_pc,            32'h40);
    applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'h800);
    checkOutput("stall1_pc",      a_pc,            32'h40);
    checkOutput("stall1_flush",   {31'b0, a_flush},   32'h0);
    checkOutput("stall1_pending", {31'b0, a_pending}, 32'h1);
    applyStimulus(1'b1, 3'b001, 32'h900, 32'h0, 32'h0);
    checkOutput("stall2_pc",      a_pc,            32'h40);
    applyStimulus(1'b1, 3'b100, 32'h0, 32'h0, 32'hA00);
    checkOutput("stall3_pending", {31'b0, a_pending}, 32'h1);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("release_pc",     a_pc,            32'h900);
    checkOutput("release_flush",  {31'b0, a_flush},   32'h1);
    checkOutput("release_pend",   {31'b0, a_pending}, 32'h0);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("after_rel_pc",   a_pc,            32'h904);

    // Release from HELD with a more urgent new request on the same edge.
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h500, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h600, 32'h0, 32'h0);
    checkOutput("rel_new_win_pc", a_pc,            32'h600);
    // Release from HELD with a less urgent new request: captured target wins.
    applyStimulus(1'b1, 3'b001, 32'h700, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'b100, 32'h0, 32'h0, 32'h780);
    checkOutput("rel_old_win_pc", a_pc,            32'h700);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("rel_old_next",   a_pc,            32'h704);

    // Wrap-around from the top of the address space.
    applyStimulus(1'b0, 3'b001, 32'hFFFF_FFFC, 32'h0, 32'h0);
    checkOutput("wrap_pc",        a_pc,            32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus",   a_pc_plus,       32'h0);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("wrapped_pc",     a_pc,            32'h0);
    checkOutput("wrapped_plus",   a_pc_plus,       32'h4);

    // Reset while a ch1 redirect is held; its target must never appear.
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h1234, 32'h0);
    checkOutput("held_pending",   {31'b0, a_pending}, 32'h1);
    reset = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    checkOutput("midrst_pc",      a_pc,            32'h0040_0000);
    checkOutput("midrst_pending", {31'b0, a_pending}, 32'h0);
    applyStimulus(1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("midrst_hold",    a_pc,            32'h0040_0000);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    checkOutput("midrst_run_pc",  a_pc,            32'h0040_0004);
    checkOutput("midrst_flush",   {31'b0, a_flush},   32'h0);

    // Narrow single-channel configuration.
    @(negedge clk);
    checkOutput("b_reset_pc",     {16'b0, b_pc},      32'h0010);
    checkOutput("b_reset_plus",   {16'b0, b_pc_plus}, 32'h0012);
    b_reset = 1'b0;
    @(negedge clk);
    checkOutput("b_run_pc1",      {16'b0, b_pc},      32'h0012);
    @(negedge clk);
    checkOutput("b_run_pc2",      {16'b0, b_pc},      32'h0014);
    b_valid  = 1'b1;
    b_target = 16'hFFFE;
    @(negedge clk);
    checkOutput("b_redir_pc",     {16'b0, b_pc},      32'hFFFE);
    checkOutput("b_redir_flush",  {31'b0, b_flush},   32'h1);
    b_valid = 1'b0;
    @(negedge clk);
    checkOutput("b_wrap_pc",      {16'b0, b_pc},      32'h0000);
    checkOutput("b_wrap_flush",   {31'b0, b_flush},   32'h0);
    b_stall  = 1'b1;
    b_valid  = 1'b1;
    b_target = 16'h0100;
    @(negedge clk);
    b_valid = 1'b0;
    checkOutput("b_stall_pc",     {16'b0, b_pc},      32'h0000);
    checkOutput("b_stall_pend",   {31'b0, b_pending}, 32'h1);
    @(negedge clk);
    checkOutput("b_stall2_pend",  {31'b0, b_pending}, 32'h1);
    b_stall = 1'b0;
    @(negedge clk);
    checkOutput("b_rel_pc",       {16'b0, b_pc},      32'h0100);
    checkOutput("b_rel_flush",    {31'b0, b_flush},   32'h1);
    checkOutput("b_rel_pend",     {31'b0, b_pending}, 32'h0);
    @(negedge clk);
    checkOutput("b_after_pc",     {16'b0, b_pc},      32'h0102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
